// File: rtl/pkg_amba3.sv
// Shared types, limits and helpers for the AMBA 3 APB register-file completer.
package pkg_amba3;

    typedef enum logic {
        APB_SLV_IDLE,
        APB_SLV_ACCESS
    } apb_slv_state_e;

    localparam int APB_MAX_WAIT = 15;

    // Number of byte-offset bits inside one data word.
    function automatic int apb_lsb(input int data_bits);
        return $clog2(data_bits / 8);
    endfunction

endpackage

// File: rtl/amba3_apb_addr_decode.sv
// Combinational APB address decode: register index plus range/alignment error.
module amba3_apb_addr_decode
    import pkg_amba3::*;
#(
    parameter int                   ADDR_BITS = 32,
    parameter int                   DATA_BITS = 32,
    parameter int                   NUM_REGS  = 16,
    parameter logic [ADDR_BITS-1:0] BASE_ADDR = '0,
    localparam int                  IDX_BITS  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic [ADDR_BITS-1:0] paddr,
    output logic [IDX_BITS-1:0]  idx,
    output logic                 err
);

    localparam int                   LSB        = apb_lsb(DATA_BITS);
    localparam logic [ADDR_BITS-1:0] LSB_MASK   = ADDR_BITS'((1 << LSB) - 1);
    localparam logic [ADDR_BITS-1:0] NUM_REGS_A = ADDR_BITS'(NUM_REGS);

    logic [ADDR_BITS-1:0] offset;
    logic [ADDR_BITS-1:0] word;

    always_comb begin
        offset = paddr - BASE_ADDR;
        word   = offset >> LSB;
        idx    = word[IDX_BITS-1:0];
        // The mask test avoids a zero-width slice when words are single bytes.
        err    = (paddr < BASE_ADDR) || (word >= NUM_REGS_A) || ((paddr & LSB_MASK) != '0);
    end

endmodule

// File: rtl/amba3_apb_regfile.sv
// APB3 register bank with wait states, hardware update port and write strobes.
// Optional pslverr output is enabled by defining AMBA3_APB_PSLVERR_EN.
module amba3_apb_regfile
    import pkg_amba3::*;
#(
    parameter int                   ADDR_BITS   = 32,
    parameter int                   DATA_BITS   = 32,
    parameter int                   NUM_REGS    = 16,
    parameter logic [ADDR_BITS-1:0] BASE_ADDR   = '0,
    parameter int                   WAIT_STATES = 0,
    parameter logic [DATA_BITS-1:0] RESET_VALUE = '0,
    localparam int                  IDX_BITS    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                          pclk,
    input  logic                          preset,
    input  logic [ADDR_BITS-1:0]          paddr,
    input  logic                          psel,
    input  logic                          penable,
    input  logic                          pwrite,
    input  logic [DATA_BITS-1:0]          pwdata,
    output logic                          pready,
    output logic [DATA_BITS-1:0]          prdata,
`ifdef AMBA3_APB_PSLVERR_EN
    output logic                          pslverr,
`endif
    input  logic                          hw_we,
    input  logic [IDX_BITS-1:0]           hw_idx,
    input  logic [DATA_BITS-1:0]          hw_wdata,
    output logic [NUM_REGS*DATA_BITS-1:0] reg_q,
    output logic [NUM_REGS-1:0]           wr_pulse
);

    localparam int                WAIT_BITS  = $clog2(APB_MAX_WAIT + 1);
    localparam logic [IDX_BITS:0] NUM_REGS_W = (IDX_BITS + 1)'(NUM_REGS);

    apb_slv_state_e         state_q, state_d;
    logic [WAIT_BITS-1:0]   wait_q, wait_d;
    logic [IDX_BITS-1:0]    idx_q, idx_d;
    logic                   write_q, write_d;
    logic                   err_q, err_d;
    logic [DATA_BITS-1:0]   regs_q [NUM_REGS];
    logic [DATA_BITS-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]    wr_pulse_q, wr_pulse_d;

    logic [IDX_BITS-1:0]    dec_idx;
    logic                   dec_err;
    logic                   commit;

    amba3_apb_addr_decode #(
        .ADDR_BITS (ADDR_BITS),
        .DATA_BITS (DATA_BITS),
        .NUM_REGS  (NUM_REGS),
        .BASE_ADDR (BASE_ADDR)
    ) u_decode (
        .paddr (paddr),
        .idx   (dec_idx),
        .err   (dec_err)
    );

    assign pready = (state_q == APB_SLV_ACCESS) && (wait_q == '0);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        wait_d  = wait_q;
        idx_d   = idx_q;
        write_d = write_q;
        err_d   = err_q;
        commit  = 1'b0;
        case (state_q)
            APB_SLV_IDLE: begin
                if (psel && !penable) begin
                    state_d = APB_SLV_ACCESS;
                    wait_d  = WAIT_BITS'(WAIT_STATES);
                    idx_d   = dec_idx;
                    write_d = pwrite;
                    err_d   = dec_err;
                end
            end
            APB_SLV_ACCESS: begin
                if (!psel) begin
                    state_d = APB_SLV_IDLE;
                    wait_d  = '0;
                end else if (penable) begin
                    if (wait_q != '0) begin
                        wait_d = wait_q - WAIT_BITS'(1);
                    end else begin
                        state_d = APB_SLV_IDLE;
                        commit  = write_q && !err_q;
                    end
                end
            end
            default: state_d = APB_SLV_IDLE;
        endcase
    end

    // The APB write is applied last so it overrides a same-register hardware write.
    always_comb begin
        regs_d     = regs_q;
        wr_pulse_d = '0;
        if (hw_we && ({1'b0, hw_idx} < NUM_REGS_W)) begin
            regs_d[hw_idx] = hw_wdata;
        end
        if (commit) begin
            regs_d[idx_q]     = pwdata;
            wr_pulse_d[idx_q] = 1'b1;
        end
    end

    always_comb begin
        prdata = '0;
        if (pready && !err_q) begin
            prdata = regs_q[idx_q];
        end
    end

`ifdef AMBA3_APB_PSLVERR_EN
    assign pslverr = pready && err_q;
`endif

    always_ff @(posedge pclk or posedge preset) begin
        // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
        if (preset) begin
            state_q    <= APB_SLV_IDLE;
            wait_q     <= '0;
            idx_q      <= '0;
            write_q    <= 1'b0;
            err_q      <= 1'b0;
            wr_pulse_q <= '0;
            // NOTE: the register array is architecturally visible, so it is reset, not left as RAM.
            regs_q     <= '{default: RESET_VALUE};
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            idx_q      <= idx_d;
            write_q    <= write_d;
            err_q      <= err_d;
            wr_pulse_q <= wr_pulse_d;
            regs_q     <= regs_d;
        end
    end

    assign wr_pulse = wr_pulse_q;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
        assign reg_q[i*DATA_BITS +: DATA_BITS] = regs_q[i];
    end

endmodule

// File: tb/tb_amba3_apb_regfile.sv
// Directed bench: zero-wait (A), three-wait (B) and two-wait (C) register files.
module tb_amba3_apb_regfile;

    localparam logic [31:0] RST_B = 32'h5A5A_0001;
    localparam logic [31:0] RST_C = 32'hCAFE_0000;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [15:0] exp_pulse;
        logic        exp_err;
    } vec_t;

    logic         pclk, preset, preset_c;
    logic [31:0]  paddr, pwdata;
    logic         penable, pwrite;
    logic         psel_a, psel_b, psel_c;
    logic         hw_we;
    logic [3:0]   hw_idx;
    logic [31:0]  hw_wdata;

    logic         pready_a, pready_b, pready_c;
    logic [31:0]  prdata_a, prdata_b, prdata_c;
    logic [511:0] reg_q_a, reg_q_b, reg_q_c;
    logic [15:0]  wr_pulse_a, wr_pulse_b, wr_pulse_c;
`ifdef AMBA3_APB_PSLVERR_EN
    logic         pslverr_a, pslverr_b, pslverr_c;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    vec_t        vecs [12];
    logic [31:0] model_a [16];

    amba3_apb_regfile #(.BASE_ADDR(32'h100), .WAIT_STATES(0), .RESET_VALUE(32'h0)) dut_a (
        .pclk(pclk), .preset(preset), .paddr(paddr), .psel(psel_a), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pready(pready_a), .prdata(prdata_a),
`ifdef AMBA3_APB_PSLVERR_EN
        .pslverr(pslverr_a),
`endif
        .hw_we(hw_we), .hw_idx(hw_idx), .hw_wdata(hw_wdata), .reg_q(reg_q_a), .wr_pulse(wr_pulse_a)
    );

    amba3_apb_regfile #(.BASE_ADDR(32'h100), .WAIT_STATES(3), .RESET_VALUE(RST_B)) dut_b (
        .pclk(pclk), .preset(preset), .paddr(paddr), .psel(psel_b), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pready(pready_b), .prdata(prdata_b),
`ifdef AMBA3_APB_PSLVERR_EN
        .pslverr(pslverr_b),
`endif
        .hw_we(1'b0), .hw_idx(4'd0), .hw_wdata(32'h0), .reg_q(reg_q_b), .wr_pulse(wr_pulse_b)
    );

    amba3_apb_regfile #(.BASE_ADDR(32'h100), .WAIT_STATES(2), .RESET_VALUE(RST_C)) dut_c (
        .pclk(pclk), .preset(preset_c), .paddr(paddr), .psel(psel_c), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pready(pready_c), .prdata(prdata_c),
`ifdef AMBA3_APB_PSLVERR_EN
        .pslverr(pslverr_c),
`endif
        .hw_we(1'b0), .hw_idx(4'd0), .hw_wdata(32'h0), .reg_q(reg_q_c), .wr_pulse(wr_pulse_c)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word(input logic [511:0] bus, input int i);
        return bus[i*32 +: 32];
    endfunction

    // Zero-wait transfer on A with per-phase checks and the strobe in the following cycle.
    task automatic xfer_a(input vec_t v, input int n);
        @(posedge pclk); #1;
        psel_a = 1'b1; penable = 1'b0; paddr = v.addr; pwrite = v.wr; pwdata = v.wdata;
        @(negedge pclk);
        check($sformatf("v%0d_setup_pready", n), pready_a, 0);
        check($sformatf("v%0d_pulse_cleared", n), wr_pulse_a, 0);
        @(posedge pclk); #1;
        penable = 1'b1;
        @(negedge pclk);
        check($sformatf("v%0d_access_pready", n), pready_a, 1);
        if (!v.wr) check($sformatf("v%0d_prdata", n), prdata_a, v.exp_rdata);
`ifdef AMBA3_APB_PSLVERR_EN
        check($sformatf("v%0d_pslverr", n), pslverr_a, v.exp_err);
`endif
        @(posedge pclk); #1;
        psel_a = 1'b0; penable = 1'b0;
        @(negedge pclk);
        check($sformatf("v%0d_wr_pulse", n), wr_pulse_a, v.exp_pulse);
        check($sformatf("v%0d_idle_pready", n), pready_a, 0);
    endtask

    // Three-wait read on B: pready low for three access cycles, high in the fourth.
    task automatic read_b(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        @(posedge pclk); #1;
        psel_b = 1'b1; penable = 1'b0; paddr = addr; pwrite = 1'b0;
        @(posedge pclk); #1;
        penable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            check($sformatf("%s_wait%0d_pready", tag, i), pready_b, 0);
            check($sformatf("%s_wait%0d_prdata", tag, i), prdata_b, 0);
        end
        @(negedge pclk);
        check($sformatf("%s_ready", tag), pready_b, 1);
        check($sformatf("%s_prdata", tag), prdata_b, exp);
        @(posedge pclk); #1;
        psel_b = 1'b0; penable = 1'b0;
        @(negedge pclk);
        check($sformatf("%s_done_pready", tag), pready_b, 0);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 32'h108, 32'hDEADBEEF, 32'h0,        16'h0004, 1'b0};
        vecs[1]  = '{1'b0, 32'h108, 32'h0,        32'hDEADBEEF, 16'h0000, 1'b0};
        vecs[2]  = '{1'b1, 32'h100, 32'h11111111, 32'h0,        16'h0001, 1'b0};
        vecs[3]  = '{1'b1, 32'h13C, 32'hFFFF0000, 32'h0,        16'h8000, 1'b0};
        vecs[4]  = '{1'b0, 32'h13C, 32'h0,        32'hFFFF0000, 16'h0000, 1'b0};
        vecs[5]  = '{1'b1, 32'h140, 32'h12345678, 32'h0,        16'h0000, 1'b1};
        vecs[6]  = '{1'b1, 32'h102, 32'h0000ABCD, 32'h0,        16'h0000, 1'b1};
        vecs[7]  = '{1'b1, 32'h0FC, 32'h00000001, 32'h0,        16'h0000, 1'b1};
        vecs[8]  = '{1'b0, 32'h140, 32'h0,        32'h0,        16'h0000, 1'b1};
        vecs[9]  = '{1'b0, 32'h100, 32'h0,        32'h11111111, 16'h0000, 1'b0};
        vecs[10] = '{1'b0, 32'h102, 32'h0,        32'h0,        16'h0000, 1'b1};
        vecs[11] = '{1'b0, 32'h104, 32'h0,        32'h0,        16'h0000, 1'b0};
        for (int i = 0; i < 16; i++) model_a[i] = 32'h0;

        preset = 1'b1; preset_c = 1'b1;
        paddr = '0; pwdata = '0; penable = 1'b0; pwrite = 1'b0;
        psel_a = 1'b0; psel_b = 1'b0; psel_c = 1'b0;
        hw_we = 1'b0; hw_idx = '0; hw_wdata = '0;
        repeat (2) @(posedge pclk);
        #1; preset = 1'b0; preset_c = 1'b0;

        // Reset state
        @(negedge pclk);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("rst_a_reg%0d", i), word(reg_q_a, i), 32'h0);
            check($sformatf("rst_b_reg%0d", i), word(reg_q_b, i), RST_B);
            check($sformatf("rst_c_reg%0d", i), word(reg_q_c, i), RST_C);
        end
        check("rst_pready", {pready_a, pready_b, pready_c}, 0);
        check("rst_prdata", {prdata_a, prdata_b, prdata_c}, 0);
        check("rst_wr_pulse", {wr_pulse_a, wr_pulse_b, wr_pulse_c}, 0);

        // Vector table on the zero-wait instance
        for (int i = 0; i < 12; i++) begin
            xfer_a(vecs[i], i);
            if (vecs[i].wr && !vecs[i].exp_err) model_a[(vecs[i].addr - 32'h100) >> 2] = vecs[i].wdata;
        end
        for (int i = 0; i < 16; i++) check($sformatf("table_reg%0d", i), word(reg_q_a, i), model_a[i]);

        // Back-to-back: write 0x110, then setup of a read in the very next cycle
        @(posedge pclk); #1;
        psel_a = 1'b1; penable = 1'b0; paddr = 32'h110; pwrite = 1'b1; pwdata = 32'h0BADF00D;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(negedge pclk);
        check("b2b_wr_pready", pready_a, 1);
        @(posedge pclk); #1;
        penable = 1'b0; pwrite = 1'b0;
        @(negedge pclk);
        check("b2b_wr_pulse", wr_pulse_a, 16'h0010);
        check("b2b_setup_pready", pready_a, 0);
        check("b2b_reg4", word(reg_q_a, 4), 32'h0BADF00D);
        @(posedge pclk); #1;
        penable = 1'b1;
        @(negedge pclk);
        check("b2b_rd_pready", pready_a, 1);
        check("b2b_rd_prdata", prdata_a, 32'h0BADF00D);
        @(posedge pclk); #1;
        psel_a = 1'b0; penable = 1'b0;

        // Collision on register 5: APB wins
        @(posedge pclk); #1;
        psel_a = 1'b1; penable = 1'b0; paddr = 32'h114; pwrite = 1'b1; pwdata = 32'h1;
        @(posedge pclk); #1;
        penable = 1'b1; hw_we = 1'b1; hw_idx = 4'd5; hw_wdata = 32'h2;
        @(posedge pclk); #1;
        psel_a = 1'b0; penable = 1'b0; hw_we = 1'b0;
        @(negedge pclk);
        check("coll_same_reg5", word(reg_q_a, 5), 32'h1);
        check("coll_same_pulse", wr_pulse_a, 16'h0020);

        // APB to register 5, hardware to register 6 on the same edge
        @(posedge pclk); #1;
        psel_a = 1'b1; penable = 1'b0; paddr = 32'h114; pwrite = 1'b1; pwdata = 32'h3;
        @(posedge pclk); #1;
        penable = 1'b1; hw_we = 1'b1; hw_idx = 4'd6; hw_wdata = 32'h4;
        @(posedge pclk); #1;
        psel_a = 1'b0; penable = 1'b0; hw_we = 1'b0;
        @(negedge pclk);
        check("coll_diff_reg5", word(reg_q_a, 5), 32'h3);
        check("coll_diff_reg6", word(reg_q_a, 6), 32'h4);
        check("coll_diff_pulse", wr_pulse_a, 16'h0020);

        // Hardware-only write: visible one cycle later, no strobe
        @(posedge pclk); #1;
        hw_we = 1'b1; hw_idx = 4'd7; hw_wdata = 32'h77;
        @(negedge pclk);
        check("hw_before_edge", word(reg_q_a, 7), 32'h0);
        @(posedge pclk); #1;
        hw_we = 1'b0;
        @(negedge pclk);
        check("hw_reg7", word(reg_q_a, 7), 32'h77);
        check("hw_no_pulse", wr_pulse_a, 16'h0);

        // Wait states on B
        read_b(32'h100, RST_B, "ws_rd");

        // Abort on B: drop psel mid-access, nothing commits, FSM back to IDLE
        @(posedge pclk); #1;
        psel_b = 1'b1; penable = 1'b0; paddr = 32'h118; pwrite = 1'b1; pwdata = 32'h12345678;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(negedge pclk);
        check("abort_pready", pready_b, 0);
        @(posedge pclk); #1;
        psel_b = 1'b0; penable = 1'b0;
        @(negedge pclk);
        check("abort_pulse0", wr_pulse_b, 16'h0);
        @(negedge pclk);
        check("abort_pulse1", wr_pulse_b, 16'h0);
        check("abort_idle_pready", pready_b, 0);
        check("abort_reg6", word(reg_q_b, 6), RST_B);
        read_b(32'h118, RST_B, "abort_rd");

        // Reset during the access phase of a two-wait write on C
        @(posedge pclk); #1;
        psel_c = 1'b1; penable = 1'b0; paddr = 32'h10C; pwrite = 1'b1; pwdata = 32'h99;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(negedge pclk);
        check("rstmid_pready_pre", pready_c, 0);
        preset_c = 1'b1;
        #1;
        check("rstmid_pready_async", pready_c, 0);
        repeat (3) @(posedge pclk);
        #1;
        psel_c = 1'b0; penable = 1'b0;
        @(negedge pclk);
        preset_c = 1'b0;
        @(negedge pclk);
        check("rstmid_reg3", word(reg_q_c, 3), RST_C);
        check("rstmid_pulse", wr_pulse_c, 16'h0);
        check("rstmid_pready", pready_c, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/amba3_apb_regfile.md
# amba3_apb_regfile

Synthesizable, parametrised APB3 completer: a bank of `NUM_REGS` word-wide registers behind an AMBA 3 APB 1.0 port. It adds programmable wait states, address-range and alignment checking, a hardware-side update port and per-register write strobes. It sits behind the APB interconnect and exposes its register contents to core logic as a flat bus.

## Interface
Parameters:
- `ADDR_BITS`, 32, width of `paddr`.
- `DATA_BITS`, 32, register/data width; must be 8, 16, 32 or 64.
- `NUM_REGS`, 16, number of registers; 1 to 256.
- `BASE_ADDR`, 0, byte address of register 0; aligned to `NUM_REGS*DATA_BITS/8`, rounded up to a power of two.
- `WAIT_STATES`, 0, extra access-phase cycles before `pready`; 0 to 15.
- `RESET_VALUE`, 0, value loaded into every register on reset.

Ports:
- `pclk` input 1: clock; all state updates on its rising edge.
- `preset` input 1: reset, asynchronous, active-high.
- `paddr` input ADDR_BITS: APB address.
- `psel` input 1: APB select.
- `penable` input 1: APB enable.
- `pwrite` input 1: 1 = write, 0 = read.
- `pwdata` input DATA_BITS: write data.
- `pready` output 1: transfer complete.
- `prdata` output DATA_BITS: read data.
- `pslverr` output 1: error response; present only with `AMBA3_APB_PSLVERR_EN`.
- `hw_we` input 1: hardware write request.
- `hw_idx` input clog2(NUM_REGS) (minimum 1): hardware target register.
- `hw_wdata` input DATA_BITS: hardware write data.
- `reg_q` output NUM_REGS*DATA_BITS: register contents; register i is at `[i*DATA_BITS +: DATA_BITS]`.
- `wr_pulse` output NUM_REGS: one-cycle strobe, bit i set on the cycle after an APB write commits to register i.

## Operation
- FSM states:
  - IDLE → ACCESS when `psel`=1 and `penable`=0 are sampled. On that edge the decoded index, the `pwrite` value, the error flag and `wait_cnt = WAIT_STATES` are latched.
  - ACCESS: while `wait_cnt != 0`, decrement `wait_cnt` each edge with `penable`=1.
  - ACCESS → IDLE on the commit edge, i.e. `psel`=1, `penable`=1, `pready`=1.
  - ACCESS → IDLE with no commit if `psel`=0 is sampled (abort).
- `pready` is combinational: (state == ACCESS) and (`wait_cnt` == 0).
- Decode, with `LSB = clog2(DATA_BITS/8)`:
  - Index = (`paddr` − `BASE_ADDR`) >> `LSB`.
  - Error if `paddr` < `BASE_ADDR`, index ≥ `NUM_REGS`, or `paddr[LSB-1:0]` ≠ 0.
- Write commit, no error: register[index] ← `pwdata`; `wr_pulse[index]` is set on the next cycle.
- Write with error: no register changes; no pulse.
- Read:
  - While `pready`=1 and no error, `prdata` = register[index], taken from the live register value.
  - Otherwise `prdata` = 0.
- Hardware port: `hw_we`=1 writes `hw_wdata` to register[`hw_idx`] on the edge. `hw_idx` ≥ `NUM_REGS` is ignored.
- Simultaneous APB commit and `hw_we` to the same register: the APB write wins. Different registers: both writes take effect.
- Back-to-back transfers: a setup phase in the cycle after a commit is accepted with no idle gap.

## Timing
- Reset (`preset`=1, effective immediately):
  - State = IDLE, `wait_cnt` = 0.
  - All registers = `RESET_VALUE`.
  - `pready`, `prdata`, `pslverr`, `wr_pulse` = 0.
  - A transfer in flight is dropped and nothing is committed.
- Setup sampled at edge T: `pready` rises in cycle T+1+`WAIT_STATES`; the commit happens at the end of that cycle.
- Zero-wait write occupies 2 cycles (setup + access). The `reg_q` update is visible in the cycle after the commit.
- `wr_pulse` is registered and lasts exactly 1 cycle.
- The hardware-port write is visible on `reg_q` one cycle after `hw_we`.

## Configuration
- `AMBA3_APB_PSLVERR_EN` defined:
  - The `pslverr` port exists.
  - It equals the latched error flag while `pready`=1, otherwise 0.
- Not defined:
  - The port is omitted.
  - Erroneous writes are silently dropped and erroneous reads return 0.
  - `pready` timing is identical in both builds.

## Structure
- `pkg_amba3` holds:
  - the enum `apb_slv_state_e` {`APB_SLV_IDLE`, `APB_SLV_ACCESS`};
  - the constant `APB_MAX_WAIT` = 15;
  - the function `apb_lsb(data_bits)`, which returns clog2 of the byte width.
- The address check goes in one combinational sub-module, `amba3_apb_addr_decode`. Its outputs are index and error. Its parameters are `ADDR_BITS`, `DATA_BITS`, `NUM_REGS` and `BASE_ADDR`.

## Test plan
- Reset check: after reset release, every `reg_q` word = `RESET_VALUE`, and `pready`, `prdata` and `wr_pulse` = 0.
- Zero-wait transfer (`WAIT_STATES`=0, `BASE_ADDR`=0x100):
  - Write 0xDEADBEEF to 0x108 → `pready` is high in the access cycle, register 2 = 0xDEADBEEF, and `wr_pulse` = 0x0004 for 1 cycle.
  - A following read of 0x108 returns 0xDEADBEEF.
- Wait states (`WAIT_STATES`=3): read of 0x100 → `pready` stays low for 3 access cycles and rises in the 4th, with `prdata` valid only then.
- Error cases (`AMBA3_APB_PSLVERR_EN` defined): write to 0x140 (out of range) and to 0x102 (misaligned) → `pslverr`=1 with `pready`, no register changes, no `wr_pulse`. Repeating the same writes without the macro → no change and no pulse.
- Write collision: APB write of 0x1 and `hw_we` write of 0x2 to register 5 on the same edge → register 5 = 0x1. The same test on registers 5 and 6 → both written.
- Mid-transfer interruptions: `preset` asserted during the access phase of a write with `WAIT_STATES`=2 → no commit, register keeps `RESET_VALUE`, `pready`=0. Dropping `psel` mid-access → FSM returns to IDLE with no commit.
